// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// synchronizes and samples the rows, builds one key code per full frame, and
// debounces that code over several frames before presenting it.
// Optional build macro: KEYPAD_GHOST_REJECT_EN -- when defined, any frame with
// two or more pressed keys reads as "no key" instead of using key priority.
module keypad_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       Clock,
   input  logic       Reset_N,
   input  logic [3:0] Keypad_Row_I,
   output logic [3:0] Keypad_Col_O,
   output logic [5:0] Keyb_Value,
   output logic       Key_Valid,
   output logic       Key_Strobe
);

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [3:0]  DEB_MAX  = 4'(DEBOUNCE_SCANS);

   logic [3:0]  rowMeta_q;
   logic [3:0]  rowSync_q;
   logic        running_q;
   logic [1:0]  colIdx_q;
   logic [1:0]  colIdx_d;
   logic [15:0] divCnt_q;
   logic [15:0] divCnt_d;
   logic [3:0]  colOut_q;
   logic [4:0]  firstCode_q;
   logic [4:0]  candidate_q;
   logic [4:0]  candidate_d;
   logic [3:0]  matchCnt_q;
   logic [3:0]  matchCnt_d;
   logic [5:0]  keybValue_q;
   logic [5:0]  keybValue_d;
   logic        strobe_q;
   logic        strobe_d;

   logic        sampleEn;
   logic        frameDone;
   logic [3:0]  rowsPressed;
   logic [1:0]  colFirstRow;
   logic [4:0]  colCode;
   logic [4:0]  firstCodeAcc;
   logic [4:0]  frameCode;
   logic        loadEn;

`ifdef KEYPAD_GHOST_REJECT_EN
   logic [1:0]  keyCount_q;
   logic [1:0]  keyCountAcc;
   logic [2:0]  colKeyCount;
   logic [2:0]  keyTotal;
`endif

   // Two-flop synchronizer for the asynchronous row inputs; idle means all rows released.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         rowMeta_q <= 4'hF;
         rowSync_q <= 4'hF;
      end else begin
         rowMeta_q <= Keypad_Row_I;
         rowSync_q <= rowMeta_q;
      end
   end

   // Column period counter and column index; a column is sampled on its last cycle.
   always_comb begin
      colIdx_d = colIdx_q;
      divCnt_d = divCnt_q;
      sampleEn = running_q && (divCnt_q == DIV_LAST);
      if (running_q) begin
         if (sampleEn) begin
            divCnt_d = 16'd0;
            colIdx_d = colIdx_q + 2'd1;
         end else begin
            divCnt_d = divCnt_q + 16'd1;
         end
      end
   end

   // Scan registers; the column drive is registered so the pins never glitch.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         running_q <= 1'b0;
         colIdx_q  <= 2'd0;
         divCnt_q  <= 16'd0;
         colOut_q  <= 4'b1111;
      end else begin
         running_q <= 1'b1;
         colIdx_q  <= colIdx_d;
         divCnt_q  <= divCnt_d;
         colOut_q  <= ~(4'b0001 << colIdx_d);
      end
   end

   // Decode the sampled column: lowest pressed row wins, giving code c*4+r+1.
   always_comb begin
      rowsPressed = ~rowSync_q;
      colFirstRow = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (rowsPressed[r]) begin
            colFirstRow = 2'(r);
         end
      end
      colCode      = {1'b0, colIdx_q, colFirstRow} + 5'd1;
      firstCodeAcc = firstCode_q;
      if ((firstCode_q == 5'd0) && (rowsPressed != 4'd0)) begin
         firstCodeAcc = colCode;
      end
   end

`ifdef KEYPAD_GHOST_REJECT_EN
   // Count pressed keys across the frame, saturating at two.
   always_comb begin
      colKeyCount = 3'd0;
      for (int r = 0; r < 4; r++) begin
         colKeyCount = colKeyCount + {2'b00, rowsPressed[r]};
      end
      keyTotal    = {1'b0, keyCount_q} + colKeyCount;
      keyCountAcc = (keyTotal >= 3'd2) ? 2'd2 : keyTotal[1:0];
      frameCode   = (keyCountAcc == 2'd2) ? 5'd0 : firstCodeAcc;
   end

   // Per-frame key count, restarted after each column-3 sample.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         keyCount_q <= 2'd0;
      end else if (sampleEn) begin
         keyCount_q <= (colIdx_q == 2'd3) ? 2'd0 : keyCountAcc;
      end
   end
`else
   // Without ghost rejection the first key in scan order is the frame code.
   always_comb begin
      frameCode = firstCodeAcc;
   end
`endif

   // Per-frame first-key accumulator, restarted after each column-3 sample.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         firstCode_q <= 5'd0;
      end else if (sampleEn) begin
         firstCode_q <= (colIdx_q == 2'd3) ? 5'd0 : firstCodeAcc;
      end
   end

   // Debounce: a frame code must repeat DEBOUNCE_SCANS frames before it is presented.
   always_comb begin
      frameDone   = sampleEn && (colIdx_q == 2'd3);
      candidate_d = candidate_q;
      matchCnt_d  = matchCnt_q;
      if (frameDone) begin
         if (frameCode == candidate_q) begin
            matchCnt_d = (matchCnt_q >= DEB_MAX) ? DEB_MAX : matchCnt_q + 4'd1;
         end else begin
            candidate_d = frameCode;
            matchCnt_d  = 4'd1;
         end
      end
      loadEn      = frameDone && (matchCnt_d == DEB_MAX) && ({1'b0, candidate_d} != keybValue_q);
      keybValue_d = loadEn ? {1'b0, candidate_d} : keybValue_q;
      strobe_d    = loadEn && (candidate_d != 5'd0);
   end

   // Debounce state and the presented key code with its one-cycle strobe.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         candidate_q <= 5'd0;
         matchCnt_q  <= 4'd0;
         keybValue_q <= 6'd0;
         strobe_q    <= 1'b0;
      end else begin
         candidate_q <= candidate_d;
         matchCnt_q  <= matchCnt_d;
         keybValue_q <= keybValue_d;
         strobe_q    <= strobe_d;
      end
   end

   assign Keypad_Col_O = colOut_q;
   assign Keyb_Value   = keybValue_q;
   assign Key_Valid    = (keybValue_q != 6'd0);
   assign Key_Strobe   = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 keypad matrix into keypad_scanner
// (SCAN_DIV=4, DEBOUNCE_SCANS=2) and checks directed and randomized scenarios
// against a frame-level reference model.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 2;
   localparam int FRAME    = 4 * SCAN_DIV;
   localparam int SETTLE   = 3 * FRAME + 8;

   logic       Clock;
   logic       Reset_N;
   logic [3:0] Keypad_Row_I;
   logic [3:0] Keypad_Col_O;
   logic [5:0] Keyb_Value;
   logic       Key_Valid;
   logic       Key_Strobe;

   logic [15:0] pressed;
   int          checks;
   int          failures;
   int          strobeCount;
   int          colErrors;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
      .Clock        (Clock),
      .Reset_N      (Reset_N),
      .Keypad_Row_I (Keypad_Row_I),
      .Keypad_Col_O (Keypad_Col_O),
      .Keyb_Value   (Keyb_Value),
      .Key_Valid    (Key_Valid),
      .Key_Strobe   (Key_Strobe)
   );

   // Clock generation.
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Keypad matrix: key (c,r) pulls row r low while column c is driven low.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         Keypad_Row_I[r] = 1'b1;
         for (int c = 0; c < 4; c++) begin
            if (!Keypad_Col_O[c] && pressed[c * 4 + r]) begin
               Keypad_Row_I[r] = 1'b0;
            end
         end
      end
   end

   // Count strobes and illegal column drives, sampled on the falling edge.
   always @(negedge Clock) begin
      if (Key_Strobe) strobeCount = strobeCount + 1;
      if ($countones(~Keypad_Col_O) > 1) colErrors = colErrors + 1;
   end

   // Reference: the code of the first pressed key in column-then-row order.
   function automatic int expectedCode(input logic [15:0] keys);
      int code;
      code = 0;
      if ($countones(keys) == 0) return 0;
`ifdef KEYPAD_GHOST_REJECT_EN
      if ($countones(keys) >= 2) return 0;
`endif
      for (int i = 15; i >= 0; i--) begin
         if (keys[i]) code = i + 1;
      end
      return code;
   endfunction

   task automatic waitCycles(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic applyStimulus(input logic [15:0] keys);
      @(negedge Clock);
      pressed = keys;
   endtask

   // Assert reset, then release it on a falling edge.
   task automatic pulseReset();
      @(negedge Clock);
      Reset_N = 1'b0;
      waitCycles(3);
      strobeCount = 0;
      Reset_N = 1'b1;
   endtask

   task automatic test_reset();
      pressed = 16'h0021;
      @(negedge Clock);
      Reset_N = 1'b0;
      waitCycles(4);
      checks++;
      if (Keypad_Col_O !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL reset_col: got %b want 1111", Keypad_Col_O);
      end
      checks++;
      if (Keyb_Value !== 6'd0 || Key_Valid !== 1'b0 || Key_Strobe !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: value=%0d valid=%b strobe=%b want 0/0/0",
                  Keyb_Value, Key_Valid, Key_Strobe);
      end
      Reset_N = 1'b1;
      #1;
      checks++;
      if (Keypad_Col_O !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL reset_col_before_edge: got %b want 1111", Keypad_Col_O);
      end
      @(posedge Clock);
      #1;
      checks++;
      if (Keypad_Col_O !== 4'b1110) begin
         failures++;
         $display("[TB] FAIL reset_first_col: got %b want 1110", Keypad_Col_O);
      end
      pressed = 16'h0000;
   endtask

   // Key '5' held from reset release: accepted at the end of frame 2.
   task automatic test_stable_press();
      int firstStrobe;
      firstStrobe = 0;
      pressed = 16'h0020;
      pulseReset();
      for (int k = 1; k <= 40; k++) begin
         @(negedge Clock);
         if (Key_Strobe && firstStrobe == 0) firstStrobe = k;
         if (k == DEB * FRAME - 1) begin
            checks++;
            if (Keyb_Value !== 6'd0) begin
               failures++;
               $display("[TB] FAIL press_early: value=%0d at cycle %0d want 0", Keyb_Value, k);
            end
         end
      end
      checks++;
      if (firstStrobe < DEB * FRAME || firstStrobe > DEB * FRAME + 1) begin
         failures++;
         $display("[TB] FAIL press_latency: strobe at cycle %0d want %0d..%0d",
                  firstStrobe, DEB * FRAME, DEB * FRAME + 1);
      end
      checks++;
      if (Keyb_Value !== 6'd6 || Key_Valid !== 1'b1 || strobeCount != 1) begin
         failures++;
         $display("[TB] FAIL press_value: value=%0d valid=%b strobes=%0d want 6/1/1",
                  Keyb_Value, Key_Valid, strobeCount);
      end
   endtask

   task automatic test_release();
      strobeCount = 0;
      applyStimulus(16'h0000);
      waitCycles(4);
      checks++;
      if (Keyb_Value !== 6'd6) begin
         failures++;
         $display("[TB] FAIL release_early: value=%0d want 6", Keyb_Value);
      end
      waitCycles(SETTLE);
      checks++;
      if (Keyb_Value !== 6'd0 || Key_Valid !== 1'b0 || strobeCount != 0) begin
         failures++;
         $display("[TB] FAIL release_value: value=%0d valid=%b strobes=%0d want 0/0/0",
                  Keyb_Value, Key_Valid, strobeCount);
      end
   endtask

   // '#' held for less than a frame must never be accepted.
   task automatic test_bounce();
      pressed = 16'h0000;
      pulseReset();
      waitCycles(20);
      strobeCount = 0;
      applyStimulus(16'h0800);
      waitCycles(12);
      applyStimulus(16'h0000);
      waitCycles(SETTLE);
      checks++;
      if (Keyb_Value !== 6'd0 || strobeCount != 0) begin
         failures++;
         $display("[TB] FAIL bounce: value=%0d strobes=%0d want 0/0", Keyb_Value, strobeCount);
      end
   endtask

   task automatic test_multi_key();
      int exp;
      pressed = 16'h0000;
      pulseReset();
      exp = expectedCode(16'h8001);
      applyStimulus(16'h8001);
      waitCycles(SETTLE);
      checks++;
      if (Keyb_Value !== 6'(exp) || strobeCount != ((exp != 0) ? 1 : 0)) begin
         failures++;
         $display("[TB] FAIL multi_key: value=%0d strobes=%0d want %0d/%0d",
                  Keyb_Value, strobeCount, exp, (exp != 0) ? 1 : 0);
      end
      applyStimulus(16'h0000);
      waitCycles(SETTLE);
   endtask

   // '9' seen for one frame, then reset: progress must be discarded.
   task automatic test_reset_mid_debounce();
      pressed = 16'h0400;
      pulseReset();
      waitCycles(20);
      @(negedge Clock);
      Reset_N = 1'b0;
      waitCycles(3);
      checks++;
      if (Keyb_Value !== 6'd0 || strobeCount != 0 || Keypad_Col_O !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL mid_reset: value=%0d strobes=%0d col=%b want 0/0/1111",
                  Keyb_Value, strobeCount, Keypad_Col_O);
      end
      Reset_N = 1'b1;
      waitCycles(DEB * FRAME - 2);
      checks++;
      if (Keyb_Value !== 6'd0) begin
         failures++;
         $display("[TB] FAIL mid_reset_early: value=%0d want 0", Keyb_Value);
      end
      waitCycles(10);
      checks++;
      if (Keyb_Value !== 6'd11 || strobeCount != 1) begin
         failures++;
         $display("[TB] FAIL mid_reset_accept: value=%0d strobes=%0d want 11/1",
                  Keyb_Value, strobeCount);
      end
      applyStimulus(16'h0000);
      waitCycles(SETTLE);
   endtask

   // Random key patterns, each held long enough to settle, versus the model.
   task automatic test_random();
      int prevCode;
      int exp;
      int expStrobes;
      int kind;
      int a;
      int b;
      logic [15:0] keys;
      pressed = 16'h0000;
      pulseReset();
      prevCode = 0;
      for (int it = 0; it < 12; it++) begin
         kind = $urandom_range(0, 3);
         a = $urandom_range(0, 15);
         b = (a + $urandom_range(1, 15)) % 16;
         keys = 16'h0000;
         if (kind == 1 || kind == 2) keys[a] = 1'b1;
         if (kind == 3) begin
            keys[a] = 1'b1;
            keys[b] = 1'b1;
         end
         exp = expectedCode(keys);
         expStrobes = (exp != prevCode && exp != 0) ? 1 : 0;
         strobeCount = 0;
         applyStimulus(keys);
         waitCycles(SETTLE);
         checks++;
         if (Keyb_Value !== 6'(exp) || Key_Valid !== (exp != 0) || strobeCount != expStrobes) begin
            failures++;
            $display("[TB] FAIL random_%0d keys=%h: value=%0d valid=%b strobes=%0d want %0d/%b/%0d",
                     it, keys, Keyb_Value, Key_Valid, strobeCount, exp, exp != 0, expStrobes);
         end
         prevCode = exp;
      end
   endtask

   task automatic checkOutput();
      checks++;
      if (colErrors != 0) begin
         failures++;
         $display("[TB] FAIL col_onehot: %0d cycles with several columns low, want 0", colErrors);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      strobeCount = 0;
      colErrors   = 0;
      pressed     = 16'h0000;
      Reset_N     = 1'b0;
      test_reset();
      test_stable_press();
      test_release();
      test_bounce();
      test_multi_key();
      test_reset_mid_debounce();
      test_random();
      checkOutput();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: Clock cycles each column is driven; legal range 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical frames needed to accept a code; legal range 1..15.
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Keypad_Row_I  input  4  raw 4x4 keypad rows, active-low, externally pulled up, asynchronous to Clock.
REQ-006 SHALL have port Keypad_Col_O  output  4  column drive, active-low, at most one bit low.
REQ-007 SHALL have port Keyb_Value  output  6  debounced key code: 0 = none, 1..16 = key; feeds the 3x6 keyboard emulator.
REQ-008 SHALL have port Key_Valid  output  1  high while Keyb_Value is nonzero.
REQ-009 SHALL have port Key_Strobe  output  1  one-cycle pulse when a new nonzero code is accepted.

Function
REQ-010 SHALL pass Keypad_Row_I through a two-flop synchronizer before any use.
REQ-011 SHALL step column index c through 0,1,2,3,0... and drive Keypad_Col_O[c] low with all other bits high, holding each column for exactly SCAN_DIV cycles.
REQ-012 SHALL sample the synchronized rows on the last cycle of each column period; row r counts as pressed when its sampled bit is 0.
REQ-013 SHALL map key (c,r) to code c*4+r+1, with column 0 = {1,4,7,*} and row 0 = top row: 1=1, 4=2, 7=3, *=4, 2=5, 5=6, 8=7, 0=8, 3=9, 6=10, 9=11, #=12, A=13, B=14, C=15, D=16.
REQ-014 SHALL form a frame code after column 3 is sampled: 0 if no key was pressed, otherwise the code of the first pressed key in ascending c then r order, subject to REQ-024.
REQ-015 SHALL keep a candidate code and a match counter: if the frame code equals the candidate, the counter increments and saturates at DEBOUNCE_SCANS; otherwise the candidate takes the frame code and the counter is set to 1.
REQ-016 SHALL, when the counter reaches DEBOUNCE_SCANS and the candidate differs from Keyb_Value, load the candidate into Keyb_Value on the cycle after the column-3 sample.
REQ-017 SHALL assert Key_Strobe for exactly that one cycle when the loaded value is nonzero, including a direct change from one nonzero code to another; a load of 0 (release) SHALL NOT strobe.
REQ-018 SHALL hold Keyb_Value constant between loads, with no glitch and no intermediate value.
REQ-019 SHALL give a stable press an acceptance latency of DEBOUNCE_SCANS frames, where one frame = 4*SCAN_DIV cycles, plus synchronizer delay.
REQ-020 SHALL implement the column-period and debounce counters as saturating or wrapping counters that never produce an out-of-range column index.

Reset
REQ-021 SHALL, while Reset_N = 0, force Keypad_Col_O=4'b1111, Keyb_Value=0, Key_Valid=0, Key_Strobe=0, and clear the candidate, counter, column index and synchronizer to idle.
REQ-022 SHALL drive Keypad_Col_O=4'b1110 on the first rising edge after Reset_N deasserts, and start a fresh column-0 period.
REQ-023 SHALL, when reset asserts mid-frame or mid-debounce, discard the partial frame and debounce progress with no strobe.

Configuration
REQ-024 SHALL support macro KEYPAD_GHOST_REJECT_EN: when defined, any frame with two or more pressed keys yields frame code 0; when undefined, the priority rule of REQ-014 applies.

Verification (bench: SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-025 SHALL cover reset: hold Reset_N=0 with rows pressed -> Col_O=1111, Keyb_Value=0, Key_Strobe=0; release -> Col_O=1110 on the next edge.
REQ-026 SHALL cover a stable press: hold key '5' (c=1,r=1) -> Keyb_Value=6, Key_Valid=1, single Key_Strobe pulse after 2 frames (32 cycles plus sync delay).
REQ-027 SHALL cover bounce: press '#' for 1 frame, then release -> Keyb_Value stays 0, no strobe.
REQ-028 SHALL cover release: release '5' after acceptance -> Keyb_Value=0 and Key_Valid=0 after 2 frames, no strobe.
REQ-029 SHALL cover multiple keys: hold '1' and 'D' together -> Keyb_Value=0 with KEYPAD_GHOST_REJECT_EN, Keyb_Value=1 with one strobe without it.
REQ-030 SHALL cover reset mid-debounce: assert Reset_N=0 after 1 frame of '9' -> no strobe, Keyb_Value=0; after release, '9' is accepted as 11 after 2 new frames.
